// File: rtl/sprite_color_ctrl_if.sv
// Sprite-position inputs and registered colour/hit outputs of sprite_color_ctrl.
// The master drives positions; the slave (the colour controller) drives colours and hit status.
interface sprite_color_ctrl_if #(
    parameter int unsigned NUM_PLAYERS = 3,
    parameter int unsigned POS_W       = 9,
    parameter int unsigned COLOR_W     = 12
);
    localparam int unsigned ID_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    logic [POS_W-1:0]               ball_pos_i;
    logic                           ball_dir_i;
    logic [NUM_PLAYERS*POS_W-1:0]   player_pos_i;
    logic [NUM_PLAYERS*COLOR_W-1:0] player_color_o;
    logic [COLOR_W-1:0]             ball_color_o;
    logic [3:0]                     hit_count_o;
    logic                           hit_pulse_o;
    logic [ID_W-1:0]                hit_id_o;

    modport master (
        output ball_pos_i, ball_dir_i, player_pos_i,
        input  player_color_o, ball_color_o, hit_count_o, hit_pulse_o, hit_id_o
    );

    modport slave (
        input  ball_pos_i, ball_dir_i, player_pos_i,
        output player_color_o, ball_color_o, hit_count_o, hit_pulse_o, hit_id_o
    );
endinterface

// File: rtl/sprite_color_ctrl.sv
// Pong sprite colour manager: edge-detected paddle hits and edge-column ball recolour.
// Define SPRITE_COLOR_LFSR_EN to take the palette index from a 4-bit LFSR instead of hit_count.
module sprite_color_ctrl #(
    parameter int unsigned        NUM_PLAYERS      = 3,
    parameter int unsigned        POS_W            = 9,
    parameter int unsigned        COLOR_W          = 12,
    parameter int unsigned        COLS             = 30,
    parameter int unsigned        ROWS             = 10,
    parameter logic [COLOR_W-1:0] RESET_COLOR      = '1,
    parameter logic [1:0]         RECOLOR_DIR_MASK = 2'b11
) (
    input logic               clk,
    input logic               reset,
    sprite_color_ctrl_if.slave bus
);
    localparam int unsigned ID_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int unsigned CH_W      = COLOR_W / 3;
    localparam int unsigned NUM_CELLS = COLS * ROWS;

    typedef enum logic {StFree, StContact} state_e;

    state_e                          state_q, state_d;
    logic [NUM_PLAYERS-1:0][COLOR_W-1:0] player_color_q, player_color_d;
    logic [COLOR_W-1:0]              ball_color_q, ball_color_d;
    logic [3:0]                      hit_count_q, hit_count_d;
    logic                            hit_pulse_q, hit_pulse_d;
    logic [ID_W-1:0]                 hit_id_q, hit_id_d;
    logic [POS_W-1:0]                prev_pos_q;
    logic [3:0]                      pal_idx;

    // Channels of the 12-bit entries are MSB-aligned into COLOR_W/3-bit channels.
    function automatic logic [COLOR_W-1:0] palette(input logic [3:0] idx);
        logic [11:0]        raw;
        logic [COLOR_W-1:0] res;
        int                 src;
        case (idx)
            4'd0:    raw = 12'h083;
            4'd1:    raw = 12'hF00;
            4'd2:    raw = 12'h0F0;
            4'd3:    raw = 12'hB29;
            4'd4:    raw = 12'hF0F;
            4'd5:    raw = 12'h0FF;
            4'd6:    raw = 12'h3A7;
            4'd7:    raw = 12'h72F;
            4'd8:    raw = 12'hFF0;
            4'd9:    raw = 12'hF00;
            4'd10:   raw = 12'h8C2;
            4'd11:   raw = 12'h00F;
            4'd12:   raw = 12'hE93;
            4'd13:   raw = 12'hF0F;
            4'd14:   raw = 12'hAA9;
            default: raw = 12'hF00;
        endcase
        res = '0;
        for (int c = 0; c < 3; c++) begin
            for (int b = 0; b < int'(CH_W); b++) begin
                src = b + 4 - int'(CH_W);
                if (src >= 0 && src < 4) res[c*int'(CH_W) + b] = raw[c*4 + src];
            end
        end
        return res;
    endfunction

    logic [31:0]            ball_pos_ext;
    logic                   pos_valid;
    logic [POS_W:0]         ball_next;
    logic [ROWS-1:0]        edge_row;
    logic [NUM_PLAYERS-1:0] adj;

    assign ball_pos_ext = 32'(bus.ball_pos_i);
    assign pos_valid    = ball_pos_ext < NUM_CELLS;
    assign ball_next    = {1'b0, bus.ball_pos_i} + {{POS_W{1'b0}}, 1'b1};

    for (genvar r = 0; r < int'(ROWS); r++) begin : g_edge
        localparam int unsigned EdgePos = r * COLS + COLS - 1;
        assign edge_row[r] = (ball_pos_ext == EdgePos);
    end

    for (genvar i = 0; i < int'(NUM_PLAYERS); i++) begin : g_adj
        assign adj[i] = pos_valid && (ball_next == {1'b0, bus.player_pos_i[i*POS_W +: POS_W]});
    end

    logic            hit_any;
    logic [ID_W-1:0] hit_idx;
    logic            recolor;

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
            if (adj[i]) begin
                hit_any = 1'b1;
                hit_idx = ID_W'(i);
            end
        end
    end

    assign recolor = pos_valid && (|edge_row) && (bus.ball_pos_i != prev_pos_q) &&
                     RECOLOR_DIR_MASK[bus.ball_dir_i];

`ifdef SPRITE_COLOR_LFSR_EN
    logic [3:0] lfsr_q, lfsr_d;
    assign pal_idx = lfsr_q;
`else
    assign pal_idx = hit_count_q;
`endif

    always_comb begin
        state_d        = state_q;
        player_color_d = player_color_q;
        ball_color_d   = ball_color_q;
        hit_count_d    = hit_count_q;
        hit_pulse_d    = 1'b0;
        hit_id_d       = hit_id_q;
`ifdef SPRITE_COLOR_LFSR_EN
        lfsr_d         = lfsr_q;
`endif
        unique case (state_q)
            StFree: begin
                if (hit_any) begin
                    player_color_d[hit_idx] = ball_color_q;
                    hit_count_d             = hit_count_q + 4'd1;
                    hit_id_d                = hit_idx;
                    hit_pulse_d             = 1'b1;
                    state_d                 = StContact;
`ifdef SPRITE_COLOR_LFSR_EN
                    lfsr_d                  = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
`endif
                end
            end
            StContact: begin
                // Only release of the paddle that was hit ends the contact.
                if (!adj[hit_id_q]) state_d = StFree;
            end
            default: state_d = StFree;
        endcase
        if (recolor) ball_color_d = palette(pal_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StFree;
            player_color_q <= {NUM_PLAYERS{RESET_COLOR}};
            ball_color_q   <= RESET_COLOR;
            hit_count_q    <= '0;
            hit_pulse_q    <= 1'b0;
            hit_id_q       <= '0;
            prev_pos_q     <= '0;
`ifdef SPRITE_COLOR_LFSR_EN
            lfsr_q         <= 4'b1001;
`endif
        end else begin
            state_q        <= state_d;
            player_color_q <= player_color_d;
            ball_color_q   <= ball_color_d;
            hit_count_q    <= hit_count_d;
            hit_pulse_q    <= hit_pulse_d;
            hit_id_q       <= hit_id_d;
            prev_pos_q     <= bus.ball_pos_i;
`ifdef SPRITE_COLOR_LFSR_EN
            lfsr_q         <= lfsr_d;
`endif
        end
    end

    assign bus.player_color_o = player_color_q;
    assign bus.ball_color_o   = ball_color_q;
    assign bus.hit_count_o    = hit_count_q;
    assign bus.hit_pulse_o    = hit_pulse_q;
    assign bus.hit_id_o       = hit_id_q;
endmodule
